// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, byte type and default receive FIFO depth.
package uart_pkg;

    localparam int unsigned UART_DATA_W                = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH_DEFAULT = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Idle counter for the UART receive FIFO; saturates at TIMEOUT_CYCLES and
// reports when that value has been reached.
module uart_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 320
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] idle_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            idle_q <= '0;
        end else if (clear) begin
            idle_q <= '0;
        end else if (idle_q != LIMIT) begin
            idle_q <= idle_q + CW'(1);
        end
    end

    assign expired = (idle_q == LIMIT);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver with FWFT read port, level and interrupts.
// Optional idle timeout interrupt enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH          = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 320
) (
    input  logic                     arst_ni,
    input  logic                     clk_i,
    input  logic [UART_DATA_W-1:0]   rx_data_i,
    input  logic                     rx_data_valid_i,
    input  logic                     rx_parity_err_i,
    input  logic [$clog2(DEPTH):0]   cfg_thresh_i,
    input  logic                     cfg_flush_i,
    output logic [UART_DATA_W-1:0]   rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     int_thresh_o,
    output logic                     int_overflow_o,
    output logic                     int_parity_err_o,
    output logic                     int_timeout_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    uart_byte_t    mem [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d, count_d;
    logic          empty, full, push, pop;
    logic          thresh_q, ovf_q, par_q;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
    assign pop  = !empty && rd_ready_i && !cfg_flush_i;
    assign push = rx_data_valid_i && (!full || pop) && !cfg_flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (cfg_flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    assign count_d = wptr_d - rptr_d;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            thresh_q <= 1'b0;
            ovf_q    <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            thresh_q <= (cfg_thresh_i != '0) && (count_d >= cfg_thresh_i);
            ovf_q    <= rx_data_valid_i && full && !pop && !cfg_flush_i;
            par_q    <= rx_parity_err_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q[AW-1:0]] <= rx_data_i;
    end

    // Storage is not reset, so the head is masked to keep rd_data_o at 0 while empty.
    assign rd_data_o        = empty ? '0 : mem[rptr_q[AW-1:0]];
    assign rd_valid_o       = !empty;
    assign count_o          = wptr_q - rptr_q;
    assign full_o           = full;
    assign int_thresh_o     = thresh_q;
    assign int_overflow_o   = ovf_q;
    assign int_parity_err_o = par_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic expired;

    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .clear  (push || pop || cfg_flush_i || empty),
        .expired(expired)
    );

    assign int_timeout_o = expired && !empty;
`else
    assign int_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model tracks
// contents and flags; a negedge monitor compares every DUT output against it.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TO    = 8;

    logic          arst_ni, clk;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_perr, flush, rd_ready;
    logic [CW-1:0] thresh;
    logic [7:0]    rd_data;
    logic [CW-1:0] count;
    logic          rd_valid, full, i_thr, i_ovf, i_par, i_to;

    uart_rx_fifo #(
        .DEPTH         (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .arst_ni         (arst_ni),
        .clk_i           (clk),
        .rx_data_i       (rx_data),
        .rx_data_valid_i (rx_valid),
        .rx_parity_err_i (rx_perr),
        .cfg_thresh_i    (thresh),
        .cfg_flush_i     (flush),
        .rd_data_o       (rd_data),
        .rd_valid_o      (rd_valid),
        .rd_ready_i      (rd_ready),
        .count_o         (count),
        .full_o          (full),
        .int_thresh_o    (i_thr),
        .int_overflow_o  (i_ovf),
        .int_parity_err_o(i_par),
        .int_timeout_o   (i_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: byte queue plus expected flag values.
    byte unsigned q[$];
    int  idle;
    bit  m_ovf, m_par, m_thr;
    bit  m_pop, m_push, m_full, m_empty;

    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            q.delete();
            idle  = 0;
            m_ovf = 0;
            m_par = 0;
            m_thr = 0;
        end else begin
            m_empty = (q.size() == 0);
            m_full  = (q.size() == DEPTH);
            m_pop   = !flush && !m_empty && rd_ready;
            m_push  = !flush && rx_valid && (!m_full || m_pop);
            m_ovf   = !flush && rx_valid && m_full && !m_pop;
            m_par   = rx_perr;
            if (flush) q.delete();
            else begin
                if (m_pop)  void'(q.pop_front());
                if (m_push) q.push_back(rx_data);
            end
            if (m_push || m_pop || flush || m_empty) idle = 0;
            else if (idle < TO) idle++;
            m_thr = (thresh != 0) && (q.size() >= int'(thresh));
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (arst_ni) begin
            check("count", 32'(count), 32'(q.size()));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
            if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
            check("int_overflow", 32'(i_ovf), 32'(m_ovf));
            check("int_parity_err", 32'(i_par), 32'(m_par));
            check("int_thresh", 32'(i_thr), 32'(m_thr));
`ifdef UART_RX_FIFO_TIMEOUT_EN
            check("int_timeout", 32'(i_to), 32'(idle == TO && q.size() != 0));
`else
            check("int_timeout", 32'(i_to), 32'd0);
`endif
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit fl, input bit pe);
        rx_valid = v;
        rx_data  = d;
        rd_ready = rdy;
        flush    = fl;
        rx_perr  = pe;
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_ints"}, 32'({i_thr, i_ovf, i_par, i_to}), 32'd0);
    endtask

    initial begin
        arst_ni  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_perr  = 1'b0;
        flush    = 1'b0;
        rd_ready = 1'b0;
        thresh   = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        arst_ni = 1'b1;
        @(posedge clk);
        #2;

        // Two pushes, then one pop.
        step(1, 8'hA5, 0, 0, 0);
        step(1, 8'h3C, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (DEPTH + 2) step(0, 0, 1, 0, 0);

        // Overfill by one, then drain.
        for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (DEPTH + 2) step(0, 0, 1, 0, 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'h77, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (DEPTH + 2) step(0, 0, 1, 0, 0);

        // Threshold at 4, then disabled.
        thresh = CW'(4);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        thresh = '0;
        for (int i = 0; i < 6; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Five entries, flush coinciding with a push.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
        step(1, 8'hEE, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Idle timeout and parity pulse.
        step(1, 8'h99, 0, 0, 0);
        repeat (TO + 3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) thresh = CW'($urandom_range(0, 17));
            if (i == 1500) begin
                #1 arst_ni = 1'b0;
                #1 check_reset_outputs("async_reset");
                @(posedge clk);
                #2 arst_ni = 1'b1;
            end
            step($urandom_range(0, 99) < ((i / 250) % 2 ? 75 : 40),
                 8'($urandom),
                 $urandom_range(0, 99) < ((i / 300) % 2 ? 30 : 70),
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 5);
        end
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
